btn_mode_router: RTL and testbench
==================================

// Module: btn_mode_router
// PURPOSE
//  Parametrised, registered successor to the tri-state button selector. Routes the debounced panel
//  buttons and per-mode UART button pulses to the single active mode (watch/stopwatch/sr04/dht11,
//  ...) as clean one-cycle pulses. Non-selected modes are driven 0, never Z. Mode switches are
//  synchronised and blanked, and buttons held across a switch or reset are masked until released.
//  Sits between the debouncers/UART command decoder and the per-mode controllers.
// PARAMETERS
//  N_BTN     4   buttons per mode
//  N_MODE    4   number of destination modes (1..2**SEL_W)
//  SEL_W     2   width of sw_sel
//  BLANK_CYC 16  cycles all outputs are held 0 after a mode change (>=1)
// PORTS
//  clk         in   1             system clock
//  rst_n       in   1             asynchronous reset, active-low
//  i_btn       in   N_BTN         debounced panel buttons, level, synchronous to clk
//  i_btn_uart  in   N_MODE*N_BTN  UART button pulses, one cycle each; mode m = bits [m*N_BTN +: N_BTN]
//  sw_sel      in   SEL_W         mode select switches, asynchronous
//  o_btn       out  N_MODE*N_BTN  one-cycle button pulses per mode, same packing as i_btn_uart
//  o_mode      out  SEL_W         currently routed mode (post-synchroniser)
//  o_mode_chg  out  1             one-cycle pulse when o_mode changes
//  o_busy      out  1             1 while in BLANK
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - o_btn=0, o_mode=0, o_mode_chg=0, o_busy=0.
//   - Synchroniser regs=0, state=RUN, btn_prev=0, mask=all 1s, so buttons held through reset are ignored.
//  sw_sel path:
//   - 2-FF synchroniser -> sel_s. sw_sel stable before edge k gives sel_s valid after edge k+1.
//   - At edge k+2, if sel_s != o_mode: o_mode<=sel_s, o_mode_chg<=1 for one cycle, state<=BLANK,
//     cnt<=BLANK_CYC-1, mask<=i_btn.
//  FSM states:
//   - RUN: route as below. Go to BLANK on a select change.
//   - BLANK: o_btn=0, o_busy=1. All HW edges and UART pulses are dropped, not queued.
//     cnt decrements each cycle. At cnt==0 go to RUN on the next edge (o_busy=0).
//     A further select change in BLANK reloads cnt, updates o_mode, pulses o_mode_chg again,
//     and ORs i_btn into mask.
//  Mask:
//   - mask[b] clears on any cycle where i_btn[b]==0, in both states.
//   - A masked bit produces no edge.
//  Routing in RUN, registered, latency 1 clock:
//   - hw_edge = i_btn & ~btn_prev & ~mask; btn_prev<=i_btn every cycle, in both states.
//   - o_btn[o_mode*N_BTN +: N_BTN] <= hw_edge | i_btn_uart[o_mode*N_BTN +: N_BTN].
//   - All other o_btn bits <= 0.
//   - A held button gives exactly one pulse. It re-arms only after release.
//  Edge cases:
//   - Simultaneous HW edge and UART pulse on the same bit: one single-cycle pulse.
//   - UART pulse for a non-selected mode: dropped, no effect.
//   - UART input held high N cycles: output high N cycles. No re-shaping; the source guarantees pulses.
//   - o_mode >= N_MODE (out-of-range switch setting): all o_btn=0. o_mode/o_mode_chg still track the switch.
//   - Reset asserted mid-BLANK: immediate return to reset values, mode 0, no o_mode_chg pulse on release.
// TESTING
//  - Reset with i_btn=4'b0001 held, release rst_n -> no o_btn pulse until btn0 released and re-pressed;
//    re-press gives one pulse on o_btn[0], 1 cycle late.
//  - sel=1 settled, press btn2 held 50 cycles -> o_btn[6] high exactly 1 cycle; other 15 bits stay 0.
//  - sel=0, i_btn_uart[1] and i_btn rising bit1 in same cycle -> single pulse on o_btn[1];
//    i_btn_uart[9] pulse meanwhile -> nothing.
//  - sw_sel 0->2 with btn3 held -> o_mode_chg at edge+3, o_busy 16 cycles, all o_btn 0 meanwhile;
//    btn3 gives no pulse until released and re-pressed.
//  - sw_sel 0->1, then 1->3 after 5 BLANK cycles -> two o_mode_chg pulses, o_mode=3,
//    o_busy lasts 16 cycles from the second change.
//  - N_MODE=3 build, sw_sel=3 -> o_mode=3, all o_btn 0 for any button or UART stimulus;
//    no X/Z on any output in any case.

Source files
------------

// File: rtl/btn_mode_router.sv
// Routes debounced panel buttons and per-mode UART pulses to the active mode as one-cycle pulses.
// Mode switches are synchronised and blanked. Buttons held across a switch or reset stay masked until released.
module btn_mode_router #(
  parameter int N_BTN     = 4,
  parameter int N_MODE    = 4,
  parameter int SEL_W     = 2,
  parameter int BLANK_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_BTN-1:0]          i_btn,
  input  logic [N_MODE*N_BTN-1:0]   i_btn_uart,
  input  logic [SEL_W-1:0]          sw_sel,
  output logic [N_MODE*N_BTN-1:0]   o_btn,
  output logic [SEL_W-1:0]          o_mode,
  output logic                      o_mode_chg,
  output logic                      o_busy
);

  localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {
    ST_RUN,
    ST_BLANK
  } state_e;

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          sync1_q, sync2_q;
  logic [SEL_W-1:0]          mode_q, mode_d;
  logic                      chg_q, chg_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [N_BTN-1:0]          prev_q;
  logic [N_BTN-1:0]          mask_q, mask_d;
  logic [N_MODE*N_BTN-1:0]   btn_q, btn_d;
  logic                      sel_chg;
  logic [N_BTN-1:0]          hw_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      sync1_q <= '0;
      sync2_q <= '0;
      mode_q  <= '0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= '0;
      mask_q  <= '1;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sw_sel;
      sync2_q <= sync1_q;
      mode_q  <= mode_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      prev_q  <= i_btn;
      mask_q  <= mask_d;
      btn_q   <= btn_d;
    end
  end

  // A select change wins over everything: it (re)starts the blanking window
  // and re-masks whatever is held right now, whether in RUN or BLANK.
  always_comb begin
    sel_chg = (sync2_q != mode_q);
    hw_edge = i_btn & ~prev_q & ~mask_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    chg_d   = 1'b0;
    mask_d  = mask_q & i_btn;
    btn_d   = '0;
    if (sel_chg) begin
      mode_d  = sync2_q;
      chg_d   = 1'b1;
      state_d = ST_BLANK;
      cnt_d   = CNT_LOAD;
      mask_d  = i_btn;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      // Out-of-range modes match no slice, so every output stays 0.
      for (int m = 0; m < N_MODE; m++) begin
        if (mode_q == SEL_W'(m)) begin
          btn_d[m*N_BTN +: N_BTN] = hw_edge | i_btn_uart[m*N_BTN +: N_BTN];
        end
      end
    end
  end

  assign o_btn      = btn_q;
  assign o_mode     = mode_q;
  assign o_mode_chg = chg_q;
  assign o_busy     = (state_q == ST_BLANK);

endmodule

// File: tb/tb_btn_mode_router.sv
// Bench for btn_mode_router: a 4-mode and a 3-mode build share stimulus and are
// compared against a cycle-level reference model built from the routing rules.
module tb_btn_mode_router;

  localparam int BLANK = 16;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_btn;
  logic [15:0] i_btn_uart;
  logic [1:0]  sw_sel;

  logic [15:0] o_btn4;
  logic [1:0]  o_mode4;
  logic        chg4, busy4;
  logic [11:0] o_btn3;
  logic [1:0]  o_mode3;
  logic        chg3, busy3;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [1:0]  selQ[$];
  logic [1:0]  mMode;
  logic        mChg;
  int          mBlank;
  logic [3:0]  mNeedRel;
  logic [3:0]  mPrev;
  logic [15:0] mBtn4;
  logic [11:0] mBtn3;

  btn_mode_router #(.N_BTN(4), .N_MODE(4), .SEL_W(2), .BLANK_CYC(BLANK)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_btn_uart(i_btn_uart), .sw_sel(sw_sel),
    .o_btn(o_btn4), .o_mode(o_mode4), .o_mode_chg(chg4), .o_busy(busy4)
  );

  btn_mode_router #(.N_BTN(4), .N_MODE(3), .SEL_W(2), .BLANK_CYC(BLANK)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_btn_uart(i_btn_uart[11:0]), .sw_sel(sw_sel),
    .o_btn(o_btn3), .o_mode(o_mode3), .o_mode_chg(chg3), .o_busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    selQ     = '{2'd0, 2'd0};
    mMode    = 2'd0;
    mChg     = 1'b0;
    mBlank   = 0;
    mNeedRel = 4'hF;
    mPrev    = 4'h0;
    mBtn4    = 16'h0;
    mBtn3    = 12'h0;
  endtask

  // Advance model by one clock using current inputs, then step the DUTs and
  // return at the following falling edge where outputs are sampled.
  task automatic tick();
    logic [1:0] selS;
    logic       change;
    logic [3:0] rise;
    logic [3:0] pulse;
    selQ.push_back(sw_sel);
    selS   = selQ.pop_front();
    change = (selS != mMode);
    rise   = i_btn & ~mPrev & ~mNeedRel;
    mBtn4  = 16'h0;
    if (!change && mBlank == 0) begin
      pulse = rise | 4'(i_btn_uart >> (int'(mMode) * 4));
      mBtn4 = 16'(pulse) << (int'(mMode) * 4);
    end
    mBtn3 = (mMode < 2'd3) ? mBtn4[11:0] : 12'h0;
    mChg  = change;
    if (change) begin
      mMode  = selS;
      mBlank = BLANK;
    end else if (mBlank > 0) begin
      mBlank = mBlank - 1;
    end
    mNeedRel = change ? i_btn : (mNeedRel & i_btn);
    mPrev    = i_btn;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_btn = 4'b0001; sw_sel = 2'd0; i_btn_uart = 16'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({o_btn4, o_mode4, chg4, busy4, o_btn3, o_mode3, chg3, busy3} !== 36'h0)
      $display("[TB] FAIL reset_async outputs=%h exp=0", {o_btn4, o_mode4, chg4, busy4, o_btn3, o_mode3, chg3, busy3});
    else nPass++;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nChecks++;
      if (o_btn4 !== 16'h0) $display("[TB] FAIL reset_held_mask o_btn=%h exp=%h", o_btn4, 16'h0);
      else nPass++;
    end
    i_btn = 4'b0000; tick(); tick();
    i_btn = 4'b0001; tick();
    nChecks++;
    if (o_btn4 !== 16'h0001) $display("[TB] FAIL reset_repress o_btn=%h exp=%h", o_btn4, 16'h0001);
    else nPass++;
    tick();
    nChecks++;
    if (o_btn4 !== 16'h0) $display("[TB] FAIL reset_repress_single o_btn=%h exp=%h", o_btn4, 16'h0);
    else nPass++;
    i_btn = 4'b0000; tick();
  endtask

  task automatic test_hold_sel1();
    int highCnt;
    int otherCnt;
    sw_sel = 2'd1;
    tick(); tick();
    nChecks++;
    if (chg4 !== 1'b0) $display("[TB] FAIL sel1_early_chg chg=%b exp=0", chg4);
    else nPass++;
    tick();
    nChecks++;
    if ({o_mode4, chg4, busy4} !== {2'd1, 1'b1, 1'b1})
      $display("[TB] FAIL sel1_chg mode/chg/busy=%b exp=%b", {o_mode4, chg4, busy4}, {2'd1, 1'b1, 1'b1});
    else nPass++;
    for (int i = 0; i < BLANK - 1; i++) begin
      tick();
      nChecks++;
      if ({chg4, busy4, o_btn4} !== {1'b0, 1'b1, 16'h0})
        $display("[TB] FAIL sel1_blank cyc=%0d chg/busy/btn=%h exp=%h", i, {chg4, busy4, o_btn4}, {1'b0, 1'b1, 16'h0});
      else nPass++;
    end
    tick();
    nChecks++;
    if (busy4 !== 1'b0) $display("[TB] FAIL sel1_blank_end busy=%b exp=0", busy4);
    else nPass++;
    i_btn = 4'b0100;
    highCnt = 0; otherCnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_btn4[6] === 1'b1) highCnt++;
      if ((o_btn4 & ~16'h0040) !== 16'h0) otherCnt++;
    end
    nChecks++;
    if (highCnt !== 1) $display("[TB] FAIL held_btn2_pulses count=%0d exp=1", highCnt);
    else nPass++;
    nChecks++;
    if (otherCnt !== 0) $display("[TB] FAIL held_btn2_other count=%0d exp=0", otherCnt);
    else nPass++;
    i_btn = 4'b0000; tick();
  endtask

  task automatic test_coincident();
    sw_sel = 2'd0;
    repeat (20) tick();
    nChecks++;
    if ({o_mode4, busy4} !== {2'd0, 1'b0}) $display("[TB] FAIL coinc_settle mode/busy=%b exp=000", {o_mode4, busy4});
    else nPass++;
    i_btn = 4'b0010; i_btn_uart = 16'h0202;
    tick();
    nChecks++;
    if (o_btn4 !== 16'h0002) $display("[TB] FAIL coinc_pulse o_btn=%h exp=%h", o_btn4, 16'h0002);
    else nPass++;
    i_btn_uart = 16'h0;
    tick();
    nChecks++;
    if (o_btn4 !== 16'h0) $display("[TB] FAIL coinc_single o_btn=%h exp=%h", o_btn4, 16'h0);
    else nPass++;
    i_btn = 4'b0000; tick();
  endtask

  task automatic test_switch_held();
    i_btn = 4'b1000;
    tick();
    nChecks++;
    if (o_btn4 !== 16'h0008) $display("[TB] FAIL sw_prepress o_btn=%h exp=%h", o_btn4, 16'h0008);
    else nPass++;
    sw_sel = 2'd2;
    tick(); tick();
    nChecks++;
    if ({o_mode4, chg4} !== {2'd0, 1'b0}) $display("[TB] FAIL sw_early mode/chg=%b exp=000", {o_mode4, chg4});
    else nPass++;
    tick();
    nChecks++;
    if ({o_mode4, chg4, busy4} !== {2'd2, 1'b1, 1'b1})
      $display("[TB] FAIL sw_chg mode/chg/busy=%b exp=%b", {o_mode4, chg4, busy4}, {2'd2, 1'b1, 1'b1});
    else nPass++;
    for (int i = 0; i < BLANK - 1; i++) begin
      i_btn_uart = 16'($urandom());
      tick();
      nChecks++;
      if ({chg4, busy4, o_btn4} !== {1'b0, 1'b1, 16'h0})
        $display("[TB] FAIL sw_blank cyc=%0d chg/busy/btn=%h exp=%h", i, {chg4, busy4, o_btn4}, {1'b0, 1'b1, 16'h0});
      else nPass++;
    end
    i_btn_uart = 16'h0;
    tick();
    nChecks++;
    if ({busy4, o_btn4} !== 17'h0) $display("[TB] FAIL sw_blank_end busy/btn=%h exp=0", {busy4, o_btn4});
    else nPass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      nChecks++;
      if (o_btn4 !== 16'h0) $display("[TB] FAIL sw_held_masked o_btn=%h exp=%h", o_btn4, 16'h0);
      else nPass++;
    end
    i_btn = 4'b0000; tick();
    i_btn = 4'b1000; tick();
    nChecks++;
    if (o_btn4 !== 16'h0800) $display("[TB] FAIL sw_repress o_btn=%h exp=%h", o_btn4, 16'h0800);
    else nPass++;
    i_btn = 4'b0000; tick();
  endtask

  task automatic test_double_switch();
    int chgCnt;
    chgCnt = 0;
    sw_sel = 2'd1;
    repeat (3) begin tick(); if (chg4 === 1'b1) chgCnt++; end
    nChecks++;
    if ({o_mode4, busy4} !== {2'd1, 1'b1}) $display("[TB] FAIL dbl_first mode/busy=%b exp=%b", {o_mode4, busy4}, {2'd1, 1'b1});
    else nPass++;
    repeat (5) begin tick(); if (chg4 === 1'b1) chgCnt++; end
    sw_sel = 2'd3;
    repeat (3) begin tick(); if (chg4 === 1'b1) chgCnt++; end
    nChecks++;
    if ({o_mode4, chg4, busy4, o_mode3, chg3} !== {2'd3, 1'b1, 1'b1, 2'd3, 1'b1})
      $display("[TB] FAIL dbl_second mode/chg/busy/mode3/chg3=%b exp=%b", {o_mode4, chg4, busy4, o_mode3, chg3}, {2'd3, 1'b1, 1'b1, 2'd3, 1'b1});
    else nPass++;
    for (int i = 0; i < BLANK - 1; i++) begin
      tick();
      if (chg4 === 1'b1) chgCnt++;
      nChecks++;
      if (busy4 !== 1'b1) $display("[TB] FAIL dbl_blank cyc=%0d busy=%b exp=1", i, busy4);
      else nPass++;
    end
    tick();
    nChecks++;
    if (busy4 !== 1'b0) $display("[TB] FAIL dbl_blank_end busy=%b exp=0", busy4);
    else nPass++;
    nChecks++;
    if (chgCnt !== 2) $display("[TB] FAIL dbl_chg_count count=%0d exp=2", chgCnt);
    else nPass++;
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 30; i++) begin
      i_btn      = 4'($urandom());
      i_btn_uart = ($urandom_range(1) == 0) ? 16'($urandom()) : 16'h0;
      tick();
      nChecks++;
      if ({o_mode3, o_btn3} !== {2'd3, 12'h0} || $isunknown({o_btn3, o_mode3, chg3, busy3}))
        $display("[TB] FAIL oor_n3 mode/btn=%h exp=%h", {o_mode3, o_btn3}, {2'd3, 12'h0});
      else nPass++;
      nChecks++;
      if (o_btn4 !== mBtn4) $display("[TB] FAIL oor_n4 o_btn=%h exp=%h", o_btn4, mBtn4);
      else nPass++;
    end
    i_btn = 4'h0; i_btn_uart = 16'h0; tick();
  endtask

  task automatic test_reset_mid_blank();
    sw_sel = 2'd1;
    repeat (7) tick();
    nChecks++;
    if (busy4 !== 1'b1) $display("[TB] FAIL midrst_pre busy=%b exp=1", busy4);
    else nPass++;
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({o_btn4, o_mode4, chg4, busy4} !== 20'h0) $display("[TB] FAIL midrst_async outputs=%h exp=0", {o_btn4, o_mode4, chg4, busy4});
    else nPass++;
    sw_sel = 2'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nChecks++;
      if ({o_mode4, chg4, busy4} !== 4'h0) $display("[TB] FAIL midrst_release mode/chg/busy=%b exp=0000", {o_mode4, chg4, busy4});
      else nPass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(39) == 0) sw_sel = 2'($urandom_range(3));
      if ($urandom_range(3) == 0) i_btn = i_btn ^ 4'($urandom_range(15));
      i_btn_uart = ($urandom_range(2) == 0) ? (16'h1 << $urandom_range(15)) : 16'h0;
      tick();
      nChecks++;
      if ({o_btn4, o_mode4, chg4, busy4} !== {mBtn4, mMode, mChg, (mBlank > 0)})
        $display("[TB] FAIL rand_n4 cyc=%0d got=%h exp=%h", i, {o_btn4, o_mode4, chg4, busy4}, {mBtn4, mMode, mChg, (mBlank > 0)});
      else nPass++;
      nChecks++;
      if ({o_btn3, o_mode3, chg3, busy3} !== {mBtn3, mMode, mChg, (mBlank > 0)})
        $display("[TB] FAIL rand_n3 cyc=%0d got=%h exp=%h", i, {o_btn3, o_mode3, chg3, busy3}, {mBtn3, mMode, mChg, (mBlank > 0)});
      else nPass++;
    end
  endtask

  initial begin
    rst_n = 1'b1; i_btn = 4'h0; i_btn_uart = 16'h0; sw_sel = 2'd0;
    model_reset();
    test_reset();
    test_hold_sel1();
    test_coincident();
    test_switch_held();
    test_double_switch();
    test_out_of_range();
    test_reset_mid_blank();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
